// File: rtl/lcd_bus_pkg.sv
// Shared types and pin reset levels for the HX8352 parallel LCD bus blocks.
package lcd_bus_pkg;
  localparam int LCD_DATA_W = 16;

  localparam logic LCD_WR_IDLE = 1'b1;
  localparam logic LCD_CS_IDLE = 1'b1;
  localparam logic LCD_RD_IDLE = 1'b1;
  localparam logic LCD_RS_RST  = 1'b0;
  localparam logic [LCD_DATA_W-1:0] LCD_DATA_RST = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR_LO,
    ST_WR_HI,
    ST_RELEASE
  } arb_state_e;
endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin select: searches upward from ptr+1 with wrap,
// so the last granted index has the lowest priority.
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               found
);
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        winner[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin burst arbiter and CS/RS/WR sequencer for the shared HX8352 bus.
// Optional owner-stall abort is enabled with LCD_ARB_TIMEOUT_EN.
module lcd_bus_arbiter import lcd_bus_pkg::*; #(
  parameter int NUM_REQ     = 3,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rs,
  input  logic [LCD_DATA_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [LCD_DATA_W-1:0]          lcd_data,
  output logic                           lcd_rs,
  output logic                           lcd_wr,
  output logic                           lcd_cs,
  output logic                           lcd_rd
);
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STB_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int CNT_W   = $clog2(STB_MAX + 1);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(WR_HIGH_CYC - 1);

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       ready_q, ready_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [LCD_DATA_W-1:0]    data_q, data_d;
  logic                     rs_q, rs_d;
  logic                     last_q, last_d;
  logic                     wr_q, wr_d;
  logic                     cs_q, cs_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0]       winner;
  logic                     found;
  logic [PTR_W-1:0]         win_idx;

  lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tout_q, tout_d;
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner[i]) win_idx = PTR_W'(i);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ready_d = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    rs_d    = rs_q;
    last_d  = last_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    // WR follows the state by one cycle, giving one cycle of data setup.
    wr_d    = (state_q != ST_WR_LO);
`ifdef LCD_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    tout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = winner;
          owner_d = win_idx;
          cs_d    = 1'b0;
          state_d = ST_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (req_valid[owner_q]) begin
          ready_d[owner_q] = 1'b1;
          data_d  = req_data[int'(owner_q)*LCD_DATA_W +: LCD_DATA_W];
          rs_d    = req_rs[owner_q];
          last_d  = req_last[owner_q];
          cnt_d   = LO_LOAD;
          state_d = ST_WR_LO;
`ifdef LCD_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          grant_d = '0;
          cs_d    = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_WR_LO: begin
        if (cnt_q == '0) begin
          cnt_d   = HI_LOAD;
          state_d = ST_WR_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (last_q) begin
          grant_d = '0;
          cs_d    = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_RELEASE: begin
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      data_q  <= LCD_DATA_RST;
      rs_q    <= LCD_RS_RST;
      last_q  <= 1'b0;
      wr_q    <= LCD_WR_IDLE;
      cs_q    <= LCD_CS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt_q <= '0;
      tout_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tout_q   <= tout_d;
    end
  end
  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign busy      = |grant_q;
  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_wr    = wr_q;
  assign lcd_cs    = cs_q;
  assign lcd_rd    = LCD_RD_IDLE;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: reset, burst timing, round-robin,
// owner hold, stall/timeout behaviour and asynchronous reset mid-strobe.
module tb_lcd_bus_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [N-1:0]  req, req_valid, req_rs, req_last;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  req_ready, grant;
  logic          busy, timeout_err;
  logic [15:0]   lcd_data;
  logic          lcd_rs, lcd_wr, lcd_cs, lcd_rd;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_bus_arbiter #(.NUM_REQ(N), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .busy(busy), .timeout_err(timeout_err), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_wr(lcd_wr), .lcd_cs(lcd_cs), .lcd_rd(lcd_rd)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_word(input int idx, input logic [15:0] d, input logic rs, input logic last);
    req_data[idx*16 +: 16] = d;
    req_rs[idx]   = rs;
    req_last[idx] = last;
  endtask

  task automatic clr_inputs();
    req = '0; req_valid = '0; req_rs = '0; req_last = '0; req_data = '0;
  endtask

  task automatic do_reset();
    step();
    n_rst = 1'b0;
    clr_inputs();
    repeat (2) step();
    n_rst = 1'b1;
  endtask

  // One-word burst; when not first, expects one idle cycle then the grant.
  task automatic burst1(input logic [N-1:0] exp_g, input logic [15:0] exp_d, input bit first);
    if (!first) begin
      step(); chk("rr_idle_gap_cs", lcd_cs, 1'b1); chk("rr_idle_busy", busy, 1'b0);
    end
    step(); chk("rr_grant", grant, exp_g);
    step(); chk("rr_ready", req_ready, exp_g); chk("rr_data", lcd_data, exp_d);
    repeat (4) step();
    chk("rr_release_busy", busy, 1'b0); chk("rr_release_cs", lcd_cs, 1'b1);
  endtask

  logic [15:0] words [3];
  logic        rss   [3];

  initial begin
    n_rst = 1'b0;
    clr_inputs();

    // Reset held: outputs stay at idle levels while req toggles
    for (int i = 0; i < 4; i++) begin
      req = (i % 2 == 0) ? 3'b111 : 3'b000;
      req_valid = req;
      step();
      chk("rst_wr", lcd_wr, 1'b1); chk("rst_cs", lcd_cs, 1'b1); chk("rst_rd", lcd_rd, 1'b1);
      chk("rst_grant", grant, 3'b000); chk("rst_data", lcd_data, 16'h0);
    end
    chk("rst_ready", req_ready, 3'b000); chk("rst_busy", busy, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0); chk("rst_tout", timeout_err, 1'b0);
    clr_inputs();
    step();
    n_rst = 1'b1;

    // Single 3-word burst from requester 1
    words[0] = 16'h002C; rss[0] = 1'b0;
    words[1] = 16'hF800; rss[1] = 1'b1;
    words[2] = 16'h07E0; rss[2] = 1'b1;
    req = 3'b010; req_valid = 3'b010;
    set_word(1, words[0], rss[0], 1'b0);
    step(); chk("sb_grant", grant, 3'b010); chk("sb_cs_lo", lcd_cs, 1'b0); chk("sb_busy", busy, 1'b1);
    for (int w = 0; w < 3; w++) begin
      step();
      chk("sb_ready", req_ready, 3'b010); chk("sb_data", lcd_data, words[w]);
      chk("sb_rs", lcd_rs, rss[w]); chk("sb_wr_setup", lcd_wr, 1'b1);
      if (w < 2) set_word(1, words[w+1], rss[w+1], (w == 1));
      else begin req = '0; req_valid = '0; end
      step(); chk("sb_wr_lo1", lcd_wr, 1'b0); chk("sb_ready_pulse", req_ready, 3'b000);
      step(); chk("sb_wr_lo2", lcd_wr, 1'b0); chk("sb_data_hold", lcd_data, words[w]);
      step(); chk("sb_wr_hi1", lcd_wr, 1'b1); chk("sb_cs_hold", lcd_cs, 1'b0);
      step(); chk("sb_wr_hi2", lcd_wr, 1'b1);
      if (w < 2) chk("sb_cs_mid", lcd_cs, 1'b0);
      else begin chk("sb_cs_end", lcd_cs, 1'b1); chk("sb_grant_end", grant, 3'b000); end
    end

    // Round-robin with all three requesting one-word bursts
    do_reset();
    req = 3'b111; req_valid = 3'b111; req_last = 3'b111;
    set_word(0, 16'hA000, 1'b1, 1'b1);
    set_word(1, 16'hA001, 1'b1, 1'b1);
    set_word(2, 16'hA002, 1'b1, 1'b1);
    burst1(3'b001, 16'hA000, 1'b1);
    burst1(3'b010, 16'hA001, 1'b0);
    burst1(3'b100, 16'hA002, 1'b0);
    burst1(3'b001, 16'hA000, 1'b0);
    req = 3'b100; req_valid = 3'b100;
    burst1(3'b100, 16'hA002, 1'b0);
    burst1(3'b100, 16'hA002, 1'b0);
    clr_inputs();

    // Owner drops req mid-burst; non-owner valid is ignored
    do_reset();
    req = 3'b001; req_valid = 3'b001;
    set_word(0, 16'h1234, 1'b1, 1'b0);
    set_word(1, 16'h5678, 1'b1, 1'b0);
    step(); chk("oh_grant", grant, 3'b001);
    req = 3'b011; req_valid = 3'b011;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 1) req[0] = 1'b0;
      chk("oh_keep_grant", grant, 3'b001);
      chk("oh_nonowner_ready", {31'b0, req_ready[1]}, 32'h0);
    end
    chk("oh_word3_accept", req_ready, 3'b001);
    req_last[0] = 1'b1;
    repeat (5) step();
    chk("oh_last_accept", req_ready, 3'b001);
    repeat (3) step();
    chk("oh_hold_till_last", grant, 3'b001);
    step(); chk("oh_release_grant", grant, 3'b000); chk("oh_release_cs", lcd_cs, 1'b1);
    step(); step();
    chk("oh_next_owner", grant, 3'b010);

    // Owner stalls in WAIT
    do_reset();
    req = 3'b011; req_valid = 3'b000;
    step(); chk("to_grant", grant, 3'b001);
`ifdef LCD_ARB_TIMEOUT_EN
    repeat (15) step();
    chk("to_not_yet", timeout_err, 1'b0); chk("to_still_owner", grant, 3'b001);
    step();
    chk("to_pulse", timeout_err, 1'b1); chk("to_cs", lcd_cs, 1'b1); chk("to_grant_clr", grant, 3'b000);
    step(); chk("to_pulse_end", timeout_err, 1'b0);
    step(); chk("to_next_owner", grant, 3'b010);
`else
    begin
      bit saw_err = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        step();
        if (timeout_err) saw_err = 1'b1;
      end
      chk("stall_grant_held", grant, 3'b001);
      chk("stall_cs_low", lcd_cs, 1'b0);
      chk("stall_no_tout", {31'b0, saw_err}, 32'h0);
    end
`endif

    // Asynchronous reset during WR low phase
    do_reset();
    req = 3'b010; req_valid = 3'b010;
    set_word(1, 16'hBEEF, 1'b1, 1'b0);
    step(); step(); step();
    chk("mr_wr_low", lcd_wr, 1'b0);
    req = 3'b111; req_valid = 3'b111;
    #3 n_rst = 1'b0;
    #1;
    chk("mr_wr", lcd_wr, 1'b1); chk("mr_cs", lcd_cs, 1'b1);
    chk("mr_grant", grant, 3'b000); chk("mr_data", lcd_data, 16'h0);
    step(); step();
    n_rst = 1'b1;
    step(); chk("mr_first_win", grant, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
